step_counter: RTL and testbench

STEP_COUNTER -- requirements
Module: step_counter

---
 rtl/step_counter_pkg.sv | 36 +++
 rtl/step_prescaler.sv | 52 +++++
 rtl/step_counter.sv | 134 +++++++++++++
 tb/tb_step_counter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_counter_pkg.sv
// step_counter_pkg: shared defaults, legal parameter ranges and the wrap/saturate
// mode enum for the step_counter block.
//
// Contents:
//   DefaultWidth/DefaultDiv/DefaultStep   - parameter defaults
//   Min*/Max* constants, max_step()       - legal parameter ranges
//   mode_e                                - arithmetic mode (wrap or clamp)
//   cnt_width()                           - prescaler counter width for a DIV
package step_counter_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultDiv   = 2;
    localparam int unsigned DefaultStep  = 1;

    localparam int unsigned MinWidth = 2;
    localparam int unsigned MaxWidth = 32;
    localparam int unsigned MinDiv   = 1;
    localparam int unsigned MaxDiv   = 256;
    localparam int unsigned MinStep  = 1;

    typedef enum logic {
        MODE_WRAP     = 1'b0,
        MODE_SATURATE = 1'b1
    } mode_e;

    // Largest legal STEP for a given WIDTH (half the counter range).
    function automatic int unsigned max_step(int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

    // A DIV of 1 still needs a 1-bit counter so the port widths stay legal.
    function automatic int unsigned cnt_width(int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: divides enabled clock cycles by DIV and flags the cycle on which
// the counter may take a step.
//
// Parameters:
//   DIV     - enabled cycles per step (1..256)
// Ports:
//   clock   - rising-edge clock
//   reset_  - asynchronous active-low reset, count returns to 0
//   enable  - count advances by one per enabled cycle
//   clear   - synchronous clear to 0; wins over enable and suppresses step
//   step    - high while the next rising edge is a step edge
module step_prescaler
    import step_counter_pkg::*;
#(
    parameter int unsigned DIV = DefaultDiv
) (
    input  logic clock,
    input  logic reset_,
    input  logic enable,
    input  logic clear,
    output logic step
);

    localparam int unsigned CntW = cnt_width(DIV);
    localparam logic [CntW-1:0] LastCnt = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            at_last;

    assign at_last = (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step = enable & ~clear & at_last;

endmodule

// File: rtl/step_counter.sv
// step_counter: prescaled up/down counter with synchronous load and wrap or
// saturate overflow handling.
//
// Build option: define STEP_COUNTER_SATURATE_EN to honour the saturate port.
// Without it the counter always wraps and saturated stays 0.
//
// Parameters:
//   WIDTH      - counter width (2..32)
//   DIV        - enabled clock cycles per step (1..256)
//   STEP       - step magnitude (1..2^(WIDTH-1))
// Ports:
//   clock      - rising-edge clock
//   reset_     - asynchronous active-low reset
//   enable     - prescaler runs and steps are permitted
//   up         - 1 adds STEP, 0 subtracts STEP
//   load_      - active-low synchronous load, beats a coincident step
//   load_value - value captured on load
//   saturate   - 1 clamps at the limits, 0 wraps
//   value      - registered count
//   tick       - one-cycle pulse alongside each stepped value
//   wrapped    - one-cycle pulse when a step crossed modulo 2^WIDTH
//   saturated  - level, high while value is held at a limit by clamping
module step_counter
    import step_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DIV   = DefaultDiv,
    parameter int unsigned STEP  = DefaultStep
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             enable,
    input  logic             up,
    input  logic             load_,
    input  logic [WIDTH-1:0] load_value,
    input  logic             saturate,
    output logic [WIDTH-1:0] value,
    output logic             tick,
    output logic             wrapped,
    output logic             saturated
);

    localparam logic [WIDTH:0] StepExt = (WIDTH + 1)'(STEP);

    logic             step_edge;
    mode_e            mode;

    logic [WIDTH-1:0] value_q,     value_d;
    logic             tick_q,      tick_d;
    logic             wrapped_q,   wrapped_d;
    logic             saturated_q, saturated_d;

    // One extra bit catches carry out (up) or borrow (down).
    logic [WIDTH:0]   sum_up;
    logic [WIDTH:0]   sum_dn;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] limit;
    logic             crossed;

    step_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clock  (clock),
        .reset_ (reset_),
        .enable (enable),
        .clear  (~load_),
        .step   (step_edge)
    );

`ifdef STEP_COUNTER_SATURATE_EN
    assign mode = saturate ? MODE_SATURATE : MODE_WRAP;
`else
    // Constant mode lets the clamp path fold away entirely.
    logic unused_saturate;
    assign unused_saturate = saturate;
    assign mode = MODE_WRAP;
`endif

    assign sum_up = {1'b0, value_q} + StepExt;
    assign sum_dn = {1'b0, value_q} - StepExt;

    always_comb begin
        if (up) begin
            raw     = sum_up[WIDTH-1:0];
            crossed = sum_up[WIDTH];
            limit   = '1;
        end else begin
            raw     = sum_dn[WIDTH-1:0];
            crossed = sum_dn[WIDTH];
            limit   = '0;
        end
    end

    always_comb begin
        value_d     = value_q;
        tick_d      = 1'b0;
        wrapped_d   = 1'b0;
        saturated_d = saturated_q;
        if (!load_) begin
            value_d     = load_value;
            saturated_d = 1'b0;
        end else if (step_edge) begin
            tick_d = 1'b1;
            if (crossed && (mode == MODE_SATURATE)) begin
                value_d     = limit;
                saturated_d = 1'b1;
            end else begin
                value_d     = raw;
                wrapped_d   = crossed;
                saturated_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            value_q     <= '0;
            tick_q      <= 1'b0;
            wrapped_q   <= 1'b0;
            saturated_q <= 1'b0;
        end else begin
            value_q     <= value_d;
            tick_q      <= tick_d;
            wrapped_q   <= wrapped_d;
            saturated_q <= saturated_d;
        end
    end

    assign value     = value_q;
    assign tick      = tick_q;
    assign wrapped   = wrapped_q;
    assign saturated = saturated_q;

endmodule

// File: tb/tb_step_counter.sv
module tb_step_counter;

    // Two instances share stimulus: the reference configuration and a narrow,
    // undivided, large-step one that exercises multi-unit overflow.
    localparam int unsigned W0 = 16;
    localparam int unsigned D0 = 3;
    localparam int unsigned S0 = 1;
    localparam int unsigned W1 = 8;
    localparam int unsigned D1 = 1;
    localparam int unsigned S1 = 5;

    logic          clock = 1'b0;
    logic          reset_;
    logic          enable;
    logic          up;
    logic          load_;
    logic [15:0]   load_value;
    logic          saturate;

    logic [15:0]   value0;
    logic          tick0, wrapped0, saturated0;
    logic [7:0]    value1;
    logic          tick1, wrapped1, saturated1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        longint val;
        int     pc;
        bit     tick;
        bit     wrap;
        bit     sat;
    } mstate_t;

    mstate_t m0, m1;

    step_counter #(.WIDTH(W0), .DIV(D0), .STEP(S0)) u_dut0 (
        .clock      (clock),
        .reset_     (reset_),
        .enable     (enable),
        .up         (up),
        .load_      (load_),
        .load_value (load_value),
        .saturate   (saturate),
        .value      (value0),
        .tick       (tick0),
        .wrapped    (wrapped0),
        .saturated  (saturated0)
    );

    step_counter #(.WIDTH(W1), .DIV(D1), .STEP(S1)) u_dut1 (
        .clock      (clock),
        .reset_     (reset_),
        .enable     (enable),
        .up         (up),
        .load_      (load_),
        .load_value (load_value[7:0]),
        .saturate   (saturate),
        .value      (value1),
        .tick       (tick1),
        .wrapped    (wrapped1),
        .saturated  (saturated1)
    );

    always #5 clock = ~clock;

    wire [29:0] act_vec = {value0, tick0, wrapped0, saturated0,
                           value1, tick1, wrapped1, saturated1};

    // Behavioural model of one rising edge, written from the counter's rules
    // using unbounded integer arithmetic.
    function automatic mstate_t model_edge(mstate_t s, int w, int div, int step, bit en,
                                           bit u, bit ld_n, longint lv, bit sat_mode);
        mstate_t n = s;
        longint  range = longint'(1) << w;
        longint  r;
        n.tick = 1'b0;
        n.wrap = 1'b0;
        if (!ld_n) begin
            n.val = lv % range;
            n.pc  = 0;
            n.sat = 1'b0;
        end else if (en) begin
            if (s.pc == div - 1) begin
                n.pc   = 0;
                n.tick = 1'b1;
                r = u ? s.val + step : s.val - step;
                if (r > range - 1 || r < 0) begin
                    if (sat_mode) begin
                        n.val = (r < 0) ? 0 : range - 1;
                        n.sat = 1'b1;
                    end else begin
                        n.val = (r < 0) ? r + range : r - range;
                        n.wrap = 1'b1;
                        n.sat = 1'b0;
                    end
                end else begin
                    n.val = r;
                    n.sat = 1'b0;
                end
            end else begin
                n.pc = s.pc + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [29:0] exp_vec();
        return {m0.val[15:0], m0.tick, m0.wrap, m0.sat,
                m1.val[7:0], m1.tick, m1.wrap, m1.sat};
    endfunction

    task automatic tick_clk();
        bit smode;
`ifdef STEP_COUNTER_SATURATE_EN
        smode = saturate;
`else
        smode = 1'b0;
`endif
        @(posedge clock);
        if (!reset_) begin
            m0 = '0;
            m1 = '0;
        end else begin
            m0 = model_edge(m0, W0, D0, S0, enable, up, load_, longint'(load_value), smode);
            m1 = model_edge(m1, W1, D1, S1, enable, up, load_,
                            longint'(load_value[7:0]), smode);
        end
        #1;
    endtask

    task automatic test_reset();
        reset_ = 1'b0; enable = 1'b1; up = 1'b1; load_ = 1'b1;
        load_value = 16'h0; saturate = 1'b0;
        m0 = '0; m1 = '0;
        #2;
        checks++;
        if (act_vec !== 30'h0) begin
            failures++;
            $display("FAIL reset_async: got %h want %h", act_vec, 30'h0);
        end
        tick_clk();
        tick_clk();
        checks++;
        if (act_vec !== exp_vec()) begin
            failures++;
            $display("FAIL reset_held: got %h want %h", act_vec, exp_vec());
        end
        reset_ = 1'b1;
    endtask

    task automatic test_count_up();
        int n_tick = 0;
        enable = 1'b1; up = 1'b1; load_ = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick_clk();
            n_tick += int'(tick0);
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL count_up cyc%0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        checks++;
        if (value0 !== 16'd3 || n_tick != 3) begin
            failures++;
            $display("FAIL count_up_total: got value=%0d ticks=%0d want value=3 ticks=3",
                     value0, n_tick);
        end
    endtask

    task automatic test_wrap();
        int n_wrap = 0;
        saturate = 1'b0; load_ = 1'b0; load_value = 16'hFFFE;
        tick_clk();
        checks++;
        if (act_vec !== exp_vec()) begin
            failures++;
            $display("FAIL wrap_load: got %h want %h", act_vec, exp_vec());
        end
        load_ = 1'b1; up = 1'b1; enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick_clk();
            n_wrap += int'(wrapped0);
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL wrap cyc%0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        checks++;
        if (value0 !== 16'h0000 || n_wrap != 1) begin
            failures++;
            $display("FAIL wrap_total: got value=%h wraps=%0d want value=0000 wraps=1",
                     value0, n_wrap);
        end
    endtask

    task automatic test_saturate();
        int n_wrap = 0;
        saturate = 1'b1; load_ = 1'b0; load_value = 16'h0001;
        tick_clk();
        load_ = 1'b1; up = 1'b0; enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick_clk();
            n_wrap += int'(wrapped0);
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL saturate cyc%0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
`ifdef STEP_COUNTER_SATURATE_EN
        checks++;
        if (value0 !== 16'h0000 || saturated0 !== 1'b1 || n_wrap != 0) begin
            failures++;
            $display("FAIL saturate_total: got value=%h sat=%b wraps=%0d want 0000 1 0",
                     value0, saturated0, n_wrap);
        end
`else
        // Saturate request is ignored: 1 -> 0 -> FFFF -> FFFE with one wrap.
        checks++;
        if (value0 !== 16'hFFFE || saturated0 !== 1'b0 || n_wrap != 1) begin
            failures++;
            $display("FAIL saturate_ignored: got value=%h sat=%b wraps=%0d want FFFE 0 1",
                     value0, saturated0, n_wrap);
        end
`endif
        saturate = 1'b0;
    endtask

    task automatic test_load_on_step();
        enable = 1'b1; up = 1'b1; load_ = 1'b0; load_value = 16'h0000;
        tick_clk();
        load_ = 1'b1;
        tick_clk();
        tick_clk();
        // Next edge would be a step edge; load must win.
        load_ = 1'b0; load_value = 16'h1234;
        tick_clk();
        checks++;
        if (value0 !== 16'h1234 || tick0 !== 1'b0 || act_vec !== exp_vec()) begin
            failures++;
            $display("FAIL load_on_step: got %h want %h", act_vec, exp_vec());
        end
        load_ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            checks++;
            if (tick0 !== (i == 2) || value0 !== ((i == 2) ? 16'h1235 : 16'h1234)) begin
                failures++;
                $display("FAIL load_next_step cyc%0d: got value=%h tick=%b", i, value0, tick0);
            end
        end
    endtask

    task automatic test_reset_and_freeze();
        load_ = 1'b0; load_value = 16'h0042;
        tick_clk();
        load_ = 1'b1;
        reset_ = 1'b0;
        m0 = '0; m1 = '0;
        #2;
        checks++;
        if (value0 !== 16'h0000 || act_vec !== 30'h0) begin
            failures++;
            $display("FAIL reset_midcycle: got %h want %h", act_vec, 30'h0);
        end
        reset_ = 1'b1;
        enable = 1'b1; up = 1'b1;
        tick_clk();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick_clk();
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL freeze cyc%0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
        // One enabled edge already consumed; the step lands two enabled edges later.
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick_clk();
            checks++;
            if (act_vec !== exp_vec() || tick0 !== (i == 1)) begin
                failures++;
                $display("FAIL unfreeze cyc%0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            enable     = ($urandom_range(0, 3) != 0);
            up         = $urandom_range(0, 1) == 1;
            load_      = ($urandom_range(0, 9) != 0);
            saturate   = $urandom_range(0, 1) == 1;
            load_value = ($urandom_range(0, 3) == 0) ? 16'hFFFD + 16'($urandom_range(0, 2))
                                                     : 16'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                reset_ = 1'b0;
                m0 = '0; m1 = '0;
                #2;
                reset_ = 1'b1;
            end
            tick_clk();
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc%0d: got %h want %h", i, act_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_saturate();
        test_load_on_step();
        test_reset_and_freeze();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
